// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if
//   Handshake/command bundle between the main control FSM, the shift
//   sequencer and the RegDesloc datapath.
//   master : main FSM side. Drives start/shift_op/amt_src and passes on
//            shamt_in from the 32-to-5 block; observes the sequencer outputs.
//   slave  : sequencer side.
//   Signals:
//     start      1-cycle request (sampled only while the sequencer is idle)
//     shift_op   00 SLL, 01 SRL, 10 SRA, 11 reserved
//     amt_src    amount source: 0 = MDR, 1 = B
//     shamt_in   reduced shift amount from the 32-to-5 block
//     rdc_ctrl   reduce-ctrl mux select
//     shift_ctrl RegDesloc command: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA
//     shift_n    RegDesloc step count
//     busy       sequencer not idle
//     done       1-cycle completion pulse
interface shift_seq_ctrl_if #(
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CTRL_W  = 3
);
  logic               start;
  logic [1:0]         shift_op;
  logic               amt_src;
  logic [SHAMT_W-1:0] shamt_in;
  logic               rdc_ctrl;
  logic [CTRL_W-1:0]  shift_ctrl;
  logic [SHAMT_W-1:0] shift_n;
  logic               busy;
  logic               done;

  modport master (
    output start, shift_op, amt_src, shamt_in,
    input  rdc_ctrl, shift_ctrl, shift_n, busy, done
  );

  modport slave (
    input  start, shift_op, amt_src, shamt_in,
    output rdc_ctrl, shift_ctrl, shift_n, busy, done
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Multi-cycle sequencer for the RegDesloc shift path. On an accepted start
//   it selects the shift-amount source, samples the reduced amount, issues a
//   LOAD, then one single-bit shift command per cycle until the amount is
//   used up, and finally pulses done.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    shift_seq_ctrl_if.slave (see interface file for signal list)
//   All outputs come straight from registers.
module shift_seq_ctrl #(
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CTRL_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  shift_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CTRL_W-1:0] CMD_NOP  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] CMD_LOAD = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] CMD_SLL  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] CMD_SRL  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] CMD_SRA  = CTRL_W'(4);

  state_t              r_state;
  logic [1:0]          r_op;
  logic [SHAMT_W-1:0]  r_cnt;
  logic                r_rdc_ctrl;
  logic [CTRL_W-1:0]   r_shift_ctrl;
  logic [SHAMT_W-1:0]  r_shift_n;
  logic                r_busy;
  logic                r_done;
  logic [CTRL_W-1:0]   w_op_cmd;

  // Decoded from the latched op only, so no input reaches an output.
  always_comb begin
    w_op_cmd = CMD_NOP;
    unique case (r_op)
      2'b00:   w_op_cmd = CMD_SLL;
      2'b01:   w_op_cmd = CMD_SRL;
      2'b10:   w_op_cmd = CMD_SRA;
      default: w_op_cmd = CMD_NOP;
    endcase
  end

  // Outputs are registered together with the state: each branch sets the
  // values that belong to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op         <= 2'b00;
      r_cnt        <= '0;
      r_rdc_ctrl   <= 1'b0;
      r_shift_ctrl <= CMD_NOP;
      r_shift_n    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_shift_ctrl <= CMD_NOP;
          r_shift_n    <= '0;
          r_done       <= 1'b0;
          if (bus.start) begin
            r_op       <= bus.shift_op;
            // rdc_ctrl is only ever updated here, so the mux select stays put
            // through IDLE for the datapath.
            r_rdc_ctrl <= bus.amt_src;
            r_busy     <= 1'b1;
            r_state    <= S_SELECT;
          end else begin
            r_busy     <= 1'b0;
          end
        end

        S_SELECT: begin
          r_cnt        <= bus.shamt_in;
          r_shift_ctrl <= CMD_LOAD;
          r_state      <= S_LOAD;
        end

        S_LOAD: begin
          if ((r_cnt == '0) || (r_op == 2'b11)) begin
            r_shift_ctrl <= CMD_NOP;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_shift_ctrl <= w_op_cmd;
            r_shift_n    <= SHAMT_W'(1);
            r_state      <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // Counter is nonzero on entry and we leave when it reaches 1, so it
          // ends at 0 and never wraps.
          r_cnt <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_shift_ctrl <= CMD_NOP;
            r_shift_n    <= '0;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_shift_ctrl <= CMD_NOP;
          r_shift_n    <= '0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdc_ctrl   = r_rdc_ctrl;
  assign bus.shift_ctrl = r_shift_ctrl;
  assign bus.shift_n    = r_shift_n;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
//   Table of operations applied through the sequencer; per-cycle expected
//   outputs are queued when each start is driven and popped as the DUT runs.
//   Hand-written sequences cover mid-operation reset.
//   Packed record layout: {rdc_ctrl, shift_ctrl[2:0], shift_n[4:0], busy, done}.
module tb_shift_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_seq_ctrl_if #(.SHAMT_W(5), .CTRL_W(3)) bus ();

  shift_seq_ctrl #(.SHAMT_W(5), .CTRL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic        src;
    logic [4:0]  shamt;
    logic [2:0]  exp_cmd;
    int unsigned exp_nsh;
    bit          disturb;
    string       name;
  } vec_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [10:0] sb_q[$];

  function automatic logic [10:0] rec(input logic rdc, input logic [2:0] ctrl,
                                      input logic [4:0] sn, input logic busy,
                                      input logic done);
    return {rdc, ctrl, sn, busy, done};
  endfunction

  function automatic logic [10:0] sample();
    return {bus.rdc_ctrl, bus.shift_ctrl, bus.shift_n, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%03h exp=%03h (rdc,ctrl,shift_n,busy,done)", name, got, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int unsigned total;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.shift_op = v.op;
    bus.amt_src  = v.src;
    bus.shamt_in = v.shamt;
    sb_q.push_back(rec(v.src, 3'b000, 5'd0, 1'b1, 1'b0));            // SELECT
    sb_q.push_back(rec(v.src, 3'b001, 5'd0, 1'b1, 1'b0));            // LOAD
    for (int unsigned i = 0; i < v.exp_nsh; i++)
      sb_q.push_back(rec(v.src, v.exp_cmd, 5'd1, 1'b1, 1'b0));       // SHIFT
    sb_q.push_back(rec(v.src, 3'b000, 5'd0, 1'b1, 1'b1));            // DONE
    sb_q.push_back(rec(v.src, 3'b000, 5'd0, 1'b0, 1'b0));            // IDLE
    total = sb_q.size();
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int unsigned k = 0; k < total; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s_c%0d", v.name, k + 1), sample(), sb_q.pop_front());
      if (v.disturb) begin
        if (k == 1) bus.shamt_in = 5'd2;
        if (k == 3) begin
          bus.start    = 1'b1;
          bus.amt_src  = ~v.src;
          bus.shift_op = 2'b11;
        end
        if (k == 4) bus.start = 1'b0;
        if (k == 2 + v.exp_nsh) bus.start = 1'b1;   // start coincident with done
        if (k == 3 + v.exp_nsh) bus.start = 1'b0;
      end
    end
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{2'b00, 1'b1, 5'd3,  3'b010, 3,  1'b0, "sll3"};
    tbl[1] = '{2'b10, 1'b0, 5'd0,  3'b100, 0,  1'b0, "sra0"};
    tbl[2] = '{2'b01, 1'b1, 5'd31, 3'b011, 31, 1'b0, "srl31"};
    tbl[3] = '{2'b00, 1'b1, 5'd5,  3'b010, 5,  1'b1, "sll5_dist"};
    tbl[4] = '{2'b11, 1'b0, 5'd7,  3'b000, 0,  1'b0, "rsv7"};
    tbl[5] = '{2'b10, 1'b1, 5'd2,  3'b100, 2,  1'b0, "sra2"};
    tbl[6] = '{2'b00, 1'b0, 5'd1,  3'b010, 1,  1'b0, "sll1"};

    bus.start    = 1'b0;
    bus.shift_op = 2'b00;
    bus.amt_src  = 1'b0;
    bus.shamt_in = 5'd0;
    reset        = 1'b0;
    #12;
    check("reset_hold", sample(), rec(1'b0, 3'b000, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", sample(), rec(1'b0, 3'b000, 5'd0, 1'b0, 1'b0));

    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Mid-operation reset: op SLL, shamt 4, src 1; reset in 2nd SHIFT cycle.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.shift_op = 2'b00;
    bus.amt_src  = 1'b1;
    bus.shamt_in = 5'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_mid_shift2", sample(), rec(1'b1, 3'b010, 5'd1, 1'b1, 1'b0));
    #2 reset = 1'b0;
    #1;
    check("rst_mid_async", sample(), rec(1'b0, 3'b000, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_mid_nodone_%0d", i), sample(), rec(1'b0, 3'b000, 5'd0, 1'b0, 1'b0));
    end
    run_op('{2'b01, 1'b0, 5'd2, 3'b011, 2, 1'b0, "post_rst_srl2"});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Multi-cycle sequencer for the shift register (RegDesloc) path. It drives the reduce-ctrl mux select (0 = MDR, 1 = B) that feeds the 32-to-5 shift-amount reduction. It loads the operand, then issues single-bit shift commands until the sampled amount is exhausted, and signals completion to the main control FSM. The main FSM supplies start, op and source, and waits on done.

Parameters:
SHAMT_W, 5, width of the shift amount and of the internal counter.
CTRL_W, 3, width of the RegDesloc command bus.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request from the main FSM; sampled only in IDLE
shift_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
amt_src  input  1  amount source: 0 = MDR, 1 = B
shamt_in  input  SHAMT_W  reduced shift amount returned from the 32-to-5 block
rdc_ctrl  output  1  registered select for the reduce-ctrl mux
shift_ctrl  output  CTRL_W  RegDesloc command: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA
shift_n  output  SHAMT_W  RegDesloc step count: 1 during SHIFT, else 0
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; rdc_ctrl = 0, shift_ctrl = 000, shift_n = 0, busy = 0, done = 0; counter = 0; latched op = 00.
- All outputs are registered or are decoded from registered state only. No combinational path exists from an input to an output.
- States: IDLE, SELECT, LOAD, SHIFT, DONE.
- IDLE:
  - shift_ctrl = NOP.
  - On start = 1: latch shift_op; rdc_ctrl <= amt_src; go to SELECT.
  - start = 0: remain in IDLE.
- SELECT:
  - One settle cycle for the mux and reduction path; shift_ctrl = NOP.
  - At the end of the cycle: counter <= shamt_in; go to LOAD.
- LOAD:
  - shift_ctrl = LOAD for exactly one cycle.
  - If counter = 0 or the latched op = 11, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - shift_ctrl = command for the latched op (SLL 010, SRL 011, SRA 100); shift_n = 1.
  - Counter decrements every cycle. When the counter = 1 at a clock edge, go to DONE.
  - The number of SHIFT cycles equals the sampled shamt exactly.
- DONE: done = 1, busy = 1, shift_ctrl = NOP; go to IDLE on the next edge.
- Latency: done is high in cycle 3 + shamt after the start-sampling edge (for shamt = 0: start edge → SELECT → LOAD → DONE).
- rdc_ctrl:
  - Holds its value from the start edge until the next accepted start.
  - It does not return to 0 in IDLE, so mux inputs stay stable for the datapath.
- start while busy: ignored, with no queueing. A start in the same cycle as done is ignored; accepted starts are back-to-back only from IDLE.
- shamt_in is sampled only in SELECT. Changes to shamt_in, MDR or B after that cycle do not affect the operation.
- shamt = 31 is the maximum: 31 SHIFT cycles. The counter never wraps and never underflows.
- Reset asserted mid-operation: immediate return to IDLE with reset values. Any partial shift in RegDesloc is abandoned, and done is not pulsed.

Test Plan:
- Reset, then release: all outputs 0 and state IDLE; start with op = 00, src = 1, shamt_in = 3 → rdc_ctrl = 1 from the next edge; shift_ctrl sequence NOP, LOAD, 010, 010, 010, NOP; done pulses exactly once, 6 cycles after the start edge.
- op = 10, src = 0, shamt_in = 0 → sequence NOP, LOAD, then done on the next cycle; no SRA cycle issued; shift_n remains 0 throughout.
- op = 01, shamt_in = 31 → exactly 31 consecutive 011 cycles with shift_n = 1; done 34 cycles after start; busy high for 34 cycles.
- Change shamt_in from 5 to 2 after SELECT, and pulse start during SHIFT → still 5 shift cycles; the second start is ignored; rdc_ctrl unchanged.
- Assert reset during the 2nd SHIFT cycle of a shamt = 4 op → outputs go to 0 asynchronously with no done pulse; a fresh start after release runs normally.
- op = 11, shamt_in = 7 → LOAD, then DONE, with zero shift commands issued.
